// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT frame controller.
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG,
        LOAD,
        DRAIN,
        DONE
    } fft_state_e;

    // Upper half of the complex input word; the imaginary part of a real sample is zero.
    localparam logic [15:0] SMP_PAD = 16'h0;

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// AXI-Stream channels between the frame controller (master) and the FFT core (slave).
interface fft_frame_ctrl_if #(
    parameter int CFG_W = 8
);
    logic             s_axis_config_tvalid;
    logic [CFG_W-1:0] s_axis_config_tdata;
    logic             s_axis_config_tready;

    logic             s_axis_data_tvalid;
    logic [31:0]      s_axis_data_tdata;
    logic             s_axis_data_tlast;
    logic             s_axis_data_tready;

    logic             m_axis_data_tvalid;
    logic [47:0]      m_axis_data_tdata;
    logic             m_axis_data_tlast;
    logic             m_axis_data_tready;

    modport master (
        output s_axis_config_tvalid, s_axis_config_tdata,
        input  s_axis_config_tready,
        output s_axis_data_tvalid, s_axis_data_tdata, s_axis_data_tlast,
        input  s_axis_data_tready,
        input  m_axis_data_tvalid, m_axis_data_tdata, m_axis_data_tlast,
        output m_axis_data_tready
    );

    modport slave (
        input  s_axis_config_tvalid, s_axis_config_tdata,
        output s_axis_config_tready,
        input  s_axis_data_tvalid, s_axis_data_tdata, s_axis_data_tlast,
        output s_axis_data_tready,
        output m_axis_data_tvalid, m_axis_data_tdata, m_axis_data_tlast,
        input  m_axis_data_tready
    );
endinterface

// File: rtl/fft_beat_cnt.sv
// Modulo-FRAME_LEN beat counter; last flags the final beat of a frame.
module fft_beat_cnt #(
    parameter int FRAME_LEN = 64
) (
    input  logic Bus2IP_Clk,
    input  logic Bus2IP_Resetn,
    input  logic clr,
    input  logic inc,
    output logic last
);
    localparam int                CNT_W   = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: non-blocking (<=) for state so every flop samples pre-edge values.
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_MAX);

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for a streaming FFT core: config beat, FRAME_LEN samples in, FRAME_LEN results out.
// Optional FFT_FRAME_CTRL_STATS_EN adds a 16-bit completed-frame counter output.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int FRAME_LEN = 64,
    parameter int CFG_W     = 8
) (
    input  logic             Bus2IP_Clk,
    input  logic             Bus2IP_Resetn,
    input  logic             start,
    input  logic [CFG_W-1:0] cfg_word,
    input  logic             smp_valid,
    input  logic [15:0]      smp_data,
    output logic             smp_ready,
    output logic             res_valid,
    output logic [47:0]      res_data,
    input  logic             res_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             event_tlast_unexpected,
    input  logic             event_tlast_missing,
`ifdef FFT_FRAME_CTRL_STATS_EN
    output logic [15:0]      frame_cnt,
`endif
    fft_frame_ctrl_if.master core
);
    fft_state_e       state_q, state_d;
    logic [CFG_W-1:0] cfg_q;
    logic             err_q;
    logic             start_acc;
    logic             in_inc, in_last;
    logic             out_inc, out_last;
    logic             err_set;

    assign start_acc = (state_q == IDLE) && start;
    assign in_inc    = (state_q == LOAD)  && smp_valid && core.s_axis_data_tready;
    assign out_inc   = (state_q == DRAIN) && core.m_axis_data_tvalid && res_ready;

    fft_beat_cnt #(.FRAME_LEN(FRAME_LEN)) u_in_cnt (
        .Bus2IP_Clk    (Bus2IP_Clk),
        .Bus2IP_Resetn (Bus2IP_Resetn),
        .clr           (start_acc),
        .inc           (in_inc),
        .last          (in_last)
    );

    fft_beat_cnt #(.FRAME_LEN(FRAME_LEN)) u_out_cnt (
        .Bus2IP_Clk    (Bus2IP_Clk),
        .Bus2IP_Resetn (Bus2IP_Resetn),
        .clr           (start_acc),
        .inc           (out_inc),
        .last          (out_last)
    );

    // A core tlast that disagrees with our own count is flagged but never ends the frame.
    assign err_set = (out_inc && (core.m_axis_data_tlast != out_last))
                   || event_tlast_unexpected || event_tlast_missing;

    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_acc) cfg_q <= cfg_word;
            if (err_set)        err_q <= 1'b1;
            else if (start_acc) err_q <= 1'b0;
        end
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d                   = state_q;
        busy                      = (state_q != IDLE);
        done                      = 1'b0;
        smp_ready                 = 1'b0;
        res_valid                 = 1'b0;
        res_data                  = '0;
        core.s_axis_config_tvalid = 1'b0;
        core.s_axis_config_tdata  = '0;
        core.s_axis_data_tvalid   = 1'b0;
        core.s_axis_data_tdata    = '0;
        core.s_axis_data_tlast    = 1'b0;
        core.m_axis_data_tready   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) state_d = CFG;
            end
            CFG: begin
                core.s_axis_config_tvalid = 1'b1;
                core.s_axis_config_tdata  = cfg_q;
                if (core.s_axis_config_tready) state_d = LOAD;
            end
            LOAD: begin
                core.s_axis_data_tvalid = smp_valid;
                core.s_axis_data_tdata  = {SMP_PAD, smp_data};
                core.s_axis_data_tlast  = in_last;
                smp_ready               = core.s_axis_data_tready;
                if (in_inc && in_last) state_d = DRAIN;
            end
            DRAIN: begin
                res_valid               = core.m_axis_data_tvalid;
                res_data                = core.m_axis_data_tdata;
                core.m_axis_data_tready = res_ready;
                if (out_inc && out_last) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign err = err_q;

`ifdef FFT_FRAME_CTRL_STATS_EN
    always_ff @(posedge Bus2IP_Clk or negedge Bus2IP_Resetn) begin
        if (!Bus2IP_Resetn) begin
            frame_cnt <= '0;
        end else if (state_q == DONE) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Randomized bench for fft_frame_ctrl against a frame-level beat-count model.
// Also checks frame_cnt when FFT_FRAME_CTRL_STATS_EN is defined.
module tb_fft_frame_ctrl;
    localparam int N  = 64;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_word = '0;
    logic          smp_valid = 1'b0;
    logic [15:0]   smp_data = '0;
    logic          smp_ready;
    logic          res_valid;
    logic [47:0]   res_data;
    logic          res_ready = 1'b0;
    logic          busy, done, err;
    logic          ev_unexp = 1'b0;
    logic          ev_miss = 1'b0;
`ifdef FFT_FRAME_CTRL_STATS_EN
    logic [15:0]   frame_cnt;
`endif

    always #5 clk = ~clk;

    fft_frame_ctrl_if #(.CFG_W(CW)) core_if ();

    fft_frame_ctrl #(.FRAME_LEN(N), .CFG_W(CW)) dut (
        .Bus2IP_Clk             (clk),
        .Bus2IP_Resetn          (rst_n),
        .start                  (start),
        .cfg_word               (cfg_word),
        .smp_valid              (smp_valid),
        .smp_data               (smp_data),
        .smp_ready              (smp_ready),
        .res_valid              (res_valid),
        .res_data               (res_data),
        .res_ready              (res_ready),
        .busy                   (busy),
        .done                   (done),
        .err                    (err),
        .event_tlast_unexpected (ev_unexp),
        .event_tlast_missing    (ev_miss),
`ifdef FFT_FRAME_CTRL_STATS_EN
        .frame_cnt              (frame_cnt),
`endif
        .core                   (core_if)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Frame-level model: a frame is active from start until both FRAME_LEN beat totals are met.
    bit         m_active, m_cfg_pend, m_err;
    int         m_in, m_out, m_frames;
    logic [7:0] m_cfg;

    function automatic int phase();
        if (!m_active)        return 0;
        else if (m_cfg_pend)  return 1;
        else if (m_in < N)    return 2;
        else if (m_out < N)   return 3;
        else                  return 4;
    endfunction

    // Stimulus knobs (percent probabilities) and tlast corruption.
    int pv_smp = 100, pv_dtr = 100, pv_mtv = 100, pv_rr = 100;
    bit bad_tlast = 1'b0;
    int bad_beat = 10;

    function automatic bit roll(input int pct);
        return $urandom_range(99, 0) < pct;
    endfunction

    initial begin
        core_if.s_axis_config_tready = 1'b0;
        core_if.s_axis_data_tready   = 1'b0;
        core_if.m_axis_data_tvalid   = 1'b0;
        core_if.m_axis_data_tdata    = '0;
        core_if.m_axis_data_tlast    = 1'b0;
        forever begin
            @(posedge clk); #1;
            smp_valid                  = roll(pv_smp);
            smp_data                   = 16'($urandom());
            core_if.s_axis_data_tready = roll(pv_dtr);
            core_if.m_axis_data_tvalid = roll(pv_mtv);
            core_if.m_axis_data_tdata  = 48'({$urandom(), $urandom()});
            core_if.m_axis_data_tlast  = bad_tlast ? (m_out == bad_beat) : (m_out == N - 1);
            res_ready                  = roll(pv_rr);
        end
    end

    // Cumulative observations of DUT handshakes.
    int mon_cfg = 0, mon_stall = 0, mon_in = 0, mon_tlast = 0, mon_tlast_at = 0;
    int mon_res = 0, mon_done = 0;
    logic [7:0] mon_cfg_data = '0;

    always @(negedge clk) begin : cmp
        int ph;
        logic [8:0] e_ctl, a_ctl;
        if (!rst_n) begin
            m_active = 0; m_cfg_pend = 0; m_err = 0; m_in = 0; m_out = 0; m_frames = 0;
        end
        ph = phase();
        e_ctl = {ph != 0, ph == 4, m_err, ph == 1,
                 ph == 2 && smp_valid, ph == 2 && m_in == N - 1,
                 ph == 2 && core_if.s_axis_data_tready,
                 ph == 3 && res_ready, ph == 3 && core_if.m_axis_data_tvalid};
        a_ctl = {busy, done, err, core_if.s_axis_config_tvalid, core_if.s_axis_data_tvalid,
                 core_if.s_axis_data_tlast, smp_ready, core_if.m_axis_data_tready, res_valid};
        check("ctrl", 64'(a_ctl), 64'(e_ctl));
        check("cfg_tdata", 64'(core_if.s_axis_config_tdata), (ph == 1) ? 64'(m_cfg) : 64'd0);
        check("data_tdata", 64'(core_if.s_axis_data_tdata), (ph == 2) ? 64'(smp_data) : 64'd0);
        check("res_data", 64'(res_data), (ph == 3) ? 64'(core_if.m_axis_data_tdata) : 64'd0);
`ifdef FFT_FRAME_CTRL_STATS_EN
        check("frame_cnt", 64'(frame_cnt), 64'(m_frames));
`endif
        if (rst_n) begin
            if (core_if.s_axis_config_tvalid) begin
                if (core_if.s_axis_config_tready) begin
                    mon_cfg++;
                    mon_cfg_data = core_if.s_axis_config_tdata;
                end else begin
                    mon_stall++;
                end
            end
            if (core_if.s_axis_data_tvalid && core_if.s_axis_data_tready) begin
                if (core_if.s_axis_data_tlast) begin
                    mon_tlast++;
                    mon_tlast_at = mon_in;
                end
                mon_in++;
            end
            if (res_valid && res_ready) mon_res++;
            if (done) mon_done++;

            case (ph)
                0: if (start) begin
                    m_active = 1; m_cfg_pend = 1; m_in = 0; m_out = 0; m_err = 0; m_cfg = cfg_word;
                end
                1: if (core_if.s_axis_config_tready) m_cfg_pend = 0;
                2: if (smp_valid && core_if.s_axis_data_tready) m_in++;
                3: if (core_if.m_axis_data_tvalid && res_ready) begin
                    if (core_if.m_axis_data_tlast != (m_out == N - 1)) m_err = 1;
                    m_out++;
                end
                default: begin
                    m_active = 0;
                    m_frames = (m_frames + 1) % 65536;
                end
            endcase
            if (ev_unexp || ev_miss) m_err = 1;
        end
    end

    int b_cfg, b_stall, b_in, b_tlast, b_res, b_done;

    task automatic snap();
        b_cfg = mon_cfg; b_stall = mon_stall; b_in = mon_in;
        b_tlast = mon_tlast; b_res = mon_res; b_done = mon_done;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input logic [7:0] w);
        start = 1'b1; cfg_word = w;
        tick();
        start = 1'b0;
    endtask

    task automatic cfg_handshake(input int delay);
        core_if.s_axis_config_tready = 1'b0;
        repeat (delay) tick();
        core_if.s_axis_config_tready = 1'b1;
        tick();
        core_if.s_axis_config_tready = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc);
        bit ok = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1; break; end
        end
        check("done_seen", 64'(ok), 64'd1);
        @(negedge clk);
        check("busy_after_done", 64'(busy), 64'd0);
        tick();
    endtask

    task automatic check_frame(input string tag);
        check({tag, "_cfg_beats"}, 64'(mon_cfg - b_cfg), 64'd1);
        check({tag, "_in_beats"}, 64'(mon_in - b_in), 64'(N));
        check({tag, "_tlast_cnt"}, 64'(mon_tlast - b_tlast), 64'd1);
        check({tag, "_tlast_idx"}, 64'(mon_tlast_at - b_in), 64'(N - 1));
        check({tag, "_res_beats"}, 64'(mon_res - b_res), 64'(N));
        check({tag, "_done_pulses"}, 64'(mon_done - b_done), 64'd1);
    endtask

    task automatic random_knobs();
        pv_smp = $urandom_range(100, 30); pv_dtr = $urandom_range(100, 30);
        pv_mtv = $urandom_range(100, 30); pv_rr  = $urandom_range(100, 30);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_cfg_valid", 64'(core_if.s_axis_config_tvalid), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Frame 1: cfg 8'h27 stalled 3 cycles, full-rate load, 50% result backpressure.
        pv_smp = 100; pv_dtr = 100; pv_mtv = 100; pv_rr = 50;
        snap();
        pulse_start(8'h27);
        cfg_handshake(3);
        wait_done(3000);
        check("f1_cfg_stall", 64'(mon_stall - b_stall), 64'd3);
        check("f1_cfg_data", 64'(mon_cfg_data), 64'h27);
        check_frame("f1");
        @(negedge clk);
        check("smp_ready_idle", 64'(smp_ready), 64'd0);
        tick();

        // Event input sets err while idle.
        ev_unexp = 1'b1; tick(); ev_unexp = 1'b0;
        @(negedge clk);
        check("err_on_event", 64'(err), 64'd1);
        tick();

        // Frame 2: core tlast on output beat 10; err clears at start, sets at beat 10.
        bad_tlast = 1'b1; bad_beat = 10;
        random_knobs();
        snap();
        pulse_start(8'($urandom()));
        @(negedge clk);
        check("err_clr_on_start", 64'(err), 64'd0);
        tick();
        cfg_handshake($urandom_range(4, 0));
        seen = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (mon_res - b_res >= 11) begin seen = 1; break; end
        end
        check("beat10_seen", 64'(seen), 64'd1);
        @(negedge clk);
        check("err_after_beat10", 64'(err), 64'd1);
        check("busy_after_beat10", 64'(busy), 64'd1);
        tick();
        wait_done(5000);
        check_frame("f2");
        bad_tlast = 1'b0;
`ifdef FFT_FRAME_CTRL_STATS_EN
        check("frame_cnt_two", 64'(frame_cnt), 64'd2);
`endif

        // Frame 3: random rates, start pulsed mid-drain must be ignored.
        random_knobs();
        snap();
        pulse_start(8'($urandom()));
        cfg_handshake($urandom_range(5, 0));
        seen = 0;
        for (int i = 0; i < 5000; i++) begin
            tick();
            if (phase() == 3 && m_out >= 5) begin seen = 1; break; end
        end
        check("drain_reached", 64'(seen), 64'd1);
        pulse_start(8'hA5);
        wait_done(5000);
        check_frame("f3");

        // Frame 4: reset while beat 20 of LOAD is presented.
        pv_smp = 100; pv_dtr = 100; pv_mtv = 100; pv_rr = 100;
        snap();
        pulse_start(8'h3C);
        cfg_handshake(0);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (mon_in - b_in >= 20) begin seen = 1; break; end
        end
        check("load_beat20", 64'(seen), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ctl", 64'({busy, done, err, core_if.s_axis_config_tvalid,
                                  core_if.s_axis_data_tvalid, core_if.s_axis_data_tlast, smp_ready,
                                  core_if.m_axis_data_tready, res_valid}), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Frame 5: clean frame after reset, tlast on beat 63 again.
        snap();
        pulse_start(8'h81);
        cfg_handshake(1);
        wait_done(3000);
        check_frame("f5");
`ifdef FFT_FRAME_CTRL_STATS_EN
        check("frame_cnt_after_rst", 64'(frame_cnt), 64'd1);
`endif

        // A few fully random frames.
        for (int f = 0; f < 3; f++) begin
            random_knobs();
            snap();
            pulse_start(8'($urandom()));
            cfg_handshake($urandom_range(6, 0));
            wait_done(6000);
            check_frame("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 64, meaning points per FFT frame; power of two, 8..1024.
REQ-002 SHALL have parameter CFG_W, default 8, meaning config word width.
REQ-003 SHALL have port Bus2IP_Clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-004 SHALL have port Bus2IP_Resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle frame request.
REQ-006 SHALL have port cfg_word, input, CFG_W bits: FFT config word; sampled on an accepted start.
REQ-007 SHALL have ports smp_valid (input, 1), smp_data (input, 16) and smp_ready (output, 1): real sample stream in.
REQ-008 SHALL have ports s_axis_config_tvalid (output, 1), s_axis_config_tdata (output, CFG_W) and s_axis_config_tready (input, 1): FFT config channel.
REQ-009 SHALL have ports s_axis_data_tvalid (output, 1), s_axis_data_tdata (output, 32), s_axis_data_tlast (output, 1) and s_axis_data_tready (input, 1): FFT input channel.
REQ-010 SHALL have ports m_axis_data_tvalid (input, 1), m_axis_data_tdata (input, 48), m_axis_data_tlast (input, 1) and m_axis_data_tready (output, 1): FFT output channel.
REQ-011 SHALL have ports res_valid (output, 1), res_data (output, 48) and res_ready (input, 1): result stream out.
REQ-012 SHALL have outputs busy (1), done (1, one-cycle pulse) and err (1, sticky), plus inputs event_tlast_unexpected (1) and event_tlast_missing (1).

Function
REQ-013 SHALL implement states IDLE, CFG, LOAD, DRAIN, DONE.
REQ-014 SHALL go IDLE->CFG on start; start SHALL be ignored outside IDLE.
REQ-015 SHALL, in CFG, hold s_axis_config_tvalid=1 with the latched cfg_word until s_axis_config_tready=1, then go to LOAD.
REQ-016 SHALL, in LOAD, pass samples combinationally: s_axis_data_tvalid=smp_valid, smp_ready=s_axis_data_tready, tdata={16'h0,smp_data}.
REQ-017 SHALL count input beats modulo FRAME_LEN and assert s_axis_data_tlast on beat FRAME_LEN-1, going to DRAIN after that beat transfers.
REQ-018 SHALL, in DRAIN, pass results: res_valid=m_axis_data_tvalid, m_axis_data_tready=res_ready, res_data=m_axis_data_tdata.
REQ-019 SHALL count output beats; on transfer of beat FRAME_LEN-1 it SHALL go to DONE.
REQ-020 SHALL, in DONE, pulse done for exactly one cycle and return to IDLE on the next cycle.
REQ-021 SHALL keep busy=1 in every state except IDLE.
REQ-022 SHALL hold smp_ready=0 and m_axis_data_tready=0 outside LOAD and DRAIN respectively.
REQ-023 SHALL set err when m_axis_data_tlast differs from (out count==FRAME_LEN-1) on a transfer, or when either event input pulses; err SHALL clear only on an accepted start.
REQ-024 SHALL, on a tlast mismatch, still complete on the count; an early tlast SHALL NOT end DRAIN.
REQ-025 SHALL give beat counters $clog2(FRAME_LEN) bits, wrapping to 0 at frame end.

Reset
REQ-026 SHALL, with Bus2IP_Resetn=0 at any time (including mid-frame), force IDLE, both counters 0, err=0, done=0, busy=0, and all tvalid/tready/tlast outputs to 0 immediately.
REQ-027 SHALL resume normal operation on the first clock edge after deassertion.

Configuration
REQ-028 SHALL honour macro FFT_FRAME_CTRL_STATS_EN: when defined, it adds output frame_cnt (16 bits), incremented on each DONE, wrapping at 0xFFFF, reset to 0.
REQ-029 SHALL, without FFT_FRAME_CTRL_STATS_EN, have no frame_cnt port or logic.

Structure
REQ-030 SHALL take the state enum and the pad constant (16'h0) from shared package fft_pkg.
REQ-031 SHALL use one sub-module, fft_beat_cnt (modulo counter with last flag), instanced twice: input and output.

Verification
REQ-032 SHALL cover: reset, start with cfg_word=8'h27 and config tready after 3 cycles -> config_tdata=8'h27 held 3 cycles, then LOAD.
REQ-033 SHALL cover: 64 samples streamed, core tready always 1 -> tlast only on beat 63, smp_ready drops afterward.
REQ-034 SHALL cover: 64 results with res_ready toggling 50% -> exactly 64 res beats, done pulses once, busy falls the cycle after done.
REQ-035 SHALL cover: core tlast on output beat 10 -> err=1, DRAIN continues to beat 63, err clears on next start.
REQ-036 SHALL cover: reset asserted during LOAD beat 20 -> all outputs 0 that cycle; next frame tlast again on beat 63.
REQ-037 SHALL cover: start pulsed during DRAIN -> ignored, no extra config beat; with FFT_FRAME_CTRL_STATS_EN, frame_cnt=2 after two frames.
